// File: rtl/toy_cpu_pkg.sv
// Shared definitions for the toy CPU control path: opcodes, ALU selects,
// sequencer state encoding and decoded-flag bundle.
// Optional single-step support is enabled with `define TOYUP_SINGLE_STEP_EN.
package toy_cpu_pkg;

    localparam int unsigned IW_DEFAULT  = 8;
    localparam int unsigned PCW_DEFAULT = 3;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExecute = 3'd3,
        StHalt    = 3'd4
`ifdef TOYUP_SINGLE_STEP_EN
        ,
        StPause   = 3'd5
`endif
    } state_e;

    // Decoded control flags, registered in DECODE and used in EXECUTE
    typedef struct packed {
        logic       acc_load;
        logic [1:0] alu_op;
        logic       out_load;
        logic       jump;
        logic       cond;
        logic       hlt;
    } dec_t;

endpackage

// File: rtl/toy_decode.sv
// Combinational opcode decoder: opcode field of the instruction register to
// the control flags consumed by the sequencer.
module toy_decode
    import toy_cpu_pkg::*;
(
    input  logic [2:0] opcode_i,
    output dec_t       dec_o
);

    // Opcode table; alu_op stays ALU_PASS for anything that does not load acc
    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OP_LDA: begin
                dec_o.acc_load = 1'b1;
                dec_o.alu_op   = ALU_PASS;
            end
            OP_ADD: begin
                dec_o.acc_load = 1'b1;
                dec_o.alu_op   = ALU_ADD;
            end
            OP_SUB: begin
                dec_o.acc_load = 1'b1;
                dec_o.alu_op   = ALU_SUB;
            end
            OP_OUT:  dec_o.out_load = 1'b1;
            OP_JMP:  dec_o.jump     = 1'b1;
            OP_JZ:   dec_o.cond     = 1'b1;
            OP_HLT:  dec_o.hlt      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/toy_ctrl_seq.sv
// Toy CPU control sequencer: FETCH/DECODE/EXECUTE around the 3-bit
// instruction counter, driving its en/clr and one-cycle datapath strobes.
// Define TOYUP_SINGLE_STEP_EN to add the step_i port and a PAUSE state
// between instructions.
module toy_ctrl_seq
    import toy_cpu_pkg::*;
#(
    parameter int unsigned IW  = IW_DEFAULT,
    parameter int unsigned PCW = PCW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
`ifdef TOYUP_SINGLE_STEP_EN
    input  logic          step_i,
`endif
    input  logic [PCW-1:0] pc_i,
    input  logic [IW-1:0]  instr_i,
    input  logic           acc_zero_i,
    output logic           pc_en_o,
    output logic           pc_clr_o,
    output logic [IW-1:0]  ir_o,
    output logic [IW-4:0]  imm_o,
    output logic           acc_load_o,
    output logic [1:0]     alu_op_o,
    output logic           out_load_o,
    output logic           halted_o,
    output logic           busy_o
);

    state_e        state_q, state_d;
    logic [IW-1:0] ir_q;
    dec_t          dec_q, dec_d;

    // The counter value is observed by the datapath only; sequencing never needs it
    logic unused_pc;
    assign unused_pc = ^pc_i;

    toy_decode u_decode (
        .opcode_i (ir_q[IW-1:IW-3]),
        .dec_o    (dec_d)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register loads in FETCH, decoded flags latch in DECODE
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ir_q  <= '0;
            dec_q <= '0;
        end else begin
            if (state_q == StFetch) begin
                ir_q <= instr_i;
            end
            if (state_q == StDecode) begin
                dec_q <= dec_d;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StHalt: begin
                if (start_i) begin
                    state_d = StFetch;
                end
            end
            StFetch:  state_d = StDecode;
            StDecode: state_d = StExecute;
            StExecute: begin
                if (dec_q.hlt) begin
                    state_d = StHalt;
                end else begin
`ifdef TOYUP_SINGLE_STEP_EN
                    state_d = StPause;
`else
                    state_d = StFetch;
`endif
                end
            end
`ifdef TOYUP_SINGLE_STEP_EN
            StPause: begin
                if (step_i) begin
                    state_d = StFetch;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs: strobes only in EXECUTE, counter clear on (re)start
    always_comb begin
        pc_en_o    = 1'b0;
        pc_clr_o   = 1'b0;
        acc_load_o = 1'b0;
        alu_op_o   = ALU_PASS;
        out_load_o = 1'b0;
        halted_o   = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            StIdle, StHalt: begin
                halted_o = (state_q == StHalt);
                if (start_i) begin
                    pc_en_o  = 1'b1;
                    pc_clr_o = 1'b1;
                end
            end
            StFetch, StDecode: busy_o = 1'b1;
            StExecute: begin
                busy_o     = 1'b1;
                acc_load_o = dec_q.acc_load;
                alu_op_o   = dec_q.acc_load ? dec_q.alu_op : ALU_PASS;
                out_load_o = dec_q.out_load;
                // HLT leaves pc on the HLT word
                pc_en_o    = !dec_q.hlt;
                pc_clr_o   = dec_q.jump | (dec_q.cond & acc_zero_i);
            end
`ifdef TOYUP_SINGLE_STEP_EN
            StPause: busy_o = 1'b1;
`endif
            default: ;
        endcase
    end

    assign ir_o  = ir_q;
    assign imm_o = ir_q[IW-4:0];

endmodule

// File: tb/tb_toy_ctrl_seq.sv
// Self-checking bench for toy_ctrl_seq: a counter + program memory model
// around the DUT, and an instruction-level reference that expands each
// executed instruction into its expected per-cycle output trace.
module tb_toy_ctrl_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       step;
    logic       acc_zero;
    logic [2:0] tb_pc;
    logic [7:0] instr;
    logic       pc_en, pc_clr, acc_load, out_load, halted, busy;
    logic [7:0] ir;
    logic [4:0] imm;
    logic [1:0] alu_op;

    logic [7:0] prog [8];

    int checks   = 0;
    int failures = 0;
    bit exp_halted;
    int pause_lo = 0;
    int pause_hi = 2;

    typedef struct packed {
        logic       start;
        logic       az;
        logic       step;
        logic       pc_en;
        logic       pc_clr;
        logic       acc_load;
        logic [1:0] alu_op;
        logic       out_load;
        logic       busy;
        logic       halted;
        logic       chk_ir;
        logic [7:0] ir;
        logic       chk_pc;
        logic [2:0] pc;
    } rec_t;

    rec_t q[$];

    toy_ctrl_seq dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
`ifdef TOYUP_SINGLE_STEP_EN
        .step_i     (step),
`endif
        .pc_i       (tb_pc),
        .instr_i    (instr),
        .acc_zero_i (acc_zero),
        .pc_en_o    (pc_en),
        .pc_clr_o   (pc_clr),
        .ir_o       (ir),
        .imm_o      (imm),
        .acc_load_o (acc_load),
        .alu_op_o   (alu_op),
        .out_load_o (out_load),
        .halted_o   (halted),
        .busy_o     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction counter and combinational program memory
    always @(posedge clk) begin
        if (!rst_n) tb_pc <= 3'd0;
        else if (pc_en) tb_pc <= pc_clr ? 3'd0 : tb_pc + 3'd1;
    end
    assign instr = prog[tb_pc];

    // Expand a run into expected cycles: start cycle, then 3 cycles per instruction
    task automatic build(input int az_mode, input int max_instr, input bit was_halted);
        rec_t       r;
        logic [2:0] p;
        logic [2:0] op;
        bit         a;
        bit         fin;
        int         n;
        q.delete();
        r = '0;
        r.start = 1'b1; r.pc_en = 1'b1; r.pc_clr = 1'b1; r.halted = was_halted;
        q.push_back(r);
        p = 3'd0; n = 0; fin = 1'b0;
        while (!fin && n < max_instr) begin
            op = prog[p][7:5];
            a  = (az_mode == 2) ? 1'($urandom_range(0, 1)) : (az_mode == 1);
            r = '0;
            r.busy = 1'b1; r.az = a; r.pc = p; r.chk_pc = 1'b1;
            r.start = ($urandom_range(0, 3) == 0); r.step = 1'($urandom_range(0, 1));
            q.push_back(r);
            r.start = ($urandom_range(0, 3) == 0); r.chk_ir = 1'b1; r.ir = prog[p];
            q.push_back(r);
            r.start = ($urandom_range(0, 3) == 0);
            case (op)
                3'd1: r.acc_load = 1'b1;
                3'd2: begin r.acc_load = 1'b1; r.alu_op = 2'b01; end
                3'd3: begin r.acc_load = 1'b1; r.alu_op = 2'b10; end
                3'd4: r.out_load = 1'b1;
                default: ;
            endcase
            r.pc_en  = (op != 3'd7);
            r.pc_clr = (op == 3'd5) || (op == 3'd6 && a);
            q.push_back(r);
            if (op == 3'd7) begin
                fin = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    r = '0;
                    r.halted = 1'b1; r.pc = p; r.chk_pc = 1'b1; r.chk_ir = 1'b1; r.ir = prog[p];
                    q.push_back(r);
                end
            end else begin
                p = r.pc_clr ? 3'd0 : p + 3'd1;
`ifdef TOYUP_SINGLE_STEP_EN
                begin
                    int np;
                    np = $urandom_range(pause_lo, pause_hi);
                    for (int k = 0; k <= np; k++) begin
                        r = '0;
                        r.busy = 1'b1; r.pc = p; r.chk_pc = 1'b1; r.chk_ir = 1'b1;
                        r.ir = prog[(p - 3'd1) & 3'd7];
                        if (op == 3'd5 || (op == 3'd6 && q[q.size()-1].az)) r.chk_ir = 1'b0;
                        r.start = 1'(($urandom_range(0, 1)));
                        r.step  = (k == np);
                        q.push_back(r);
                    end
                end
`endif
            end
            n++;
        end
        exp_halted = fin;
    endtask

    // Drive the expected trace and compare every cycle at the falling edge
    task automatic run_trace(input string tag);
        foreach (q[i]) begin
            start = q[i].start; acc_zero = q[i].az; step = q[i].step;
            @(negedge clk);
            checks++;
            if (pc_en !== q[i].pc_en) begin
                failures++; $display("FAIL %s[%0d] pc_en got=%b exp=%b", tag, i, pc_en, q[i].pc_en);
            end
            checks++;
            if (pc_clr !== q[i].pc_clr) begin
                failures++; $display("FAIL %s[%0d] pc_clr got=%b exp=%b", tag, i, pc_clr, q[i].pc_clr);
            end
            checks++;
            if (acc_load !== q[i].acc_load || alu_op !== q[i].alu_op) begin
                failures++;
                $display("FAIL %s[%0d] acc_load/alu_op got=%b/%b exp=%b/%b", tag, i, acc_load,
                         alu_op, q[i].acc_load, q[i].alu_op);
            end
            checks++;
            if (out_load !== q[i].out_load) begin
                failures++; $display("FAIL %s[%0d] out_load got=%b exp=%b", tag, i, out_load, q[i].out_load);
            end
            checks++;
            if (busy !== q[i].busy || halted !== q[i].halted) begin
                failures++;
                $display("FAIL %s[%0d] busy/halted got=%b/%b exp=%b/%b", tag, i, busy, halted,
                         q[i].busy, q[i].halted);
            end
            if (q[i].chk_pc) begin
                checks++;
                if (tb_pc !== q[i].pc) begin
                    failures++; $display("FAIL %s[%0d] pc got=%0d exp=%0d", tag, i, tb_pc, q[i].pc);
                end
            end
            if (q[i].chk_ir) begin
                checks++;
                if (ir !== q[i].ir || imm !== (q[i].ir & 8'h1f)) begin
                    failures++;
                    $display("FAIL %s[%0d] ir/imm got=%h/%h exp=%h", tag, i, ir, imm, q[i].ir);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        step  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step = 1'b0; acc_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({pc_en, pc_clr, acc_load, alu_op, out_load, halted, busy} !== 8'h00 ||
                ir !== 8'h00 || imm !== 5'h00) begin
                failures++;
                $display("FAIL reset[%0d] outs got=%b ir=%h exp all zero", i,
                         {pc_en, pc_clr, acc_load, alu_op, out_load, halted, busy}, ir);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_program();
        foreach (prog[i]) prog[i] = 8'h00;
        prog[0] = 8'h25; prog[1] = 8'h43; prog[2] = 8'h80; prog[3] = 8'he0;
        build(2, 10, 1'b0);
        run_trace("prog");
        checks++;
        if (tb_pc !== 3'd3 || halted !== 1'b1) begin
            failures++; $display("FAIL prog_halt pc/halted got=%0d/%b exp=3/1", tb_pc, halted);
        end
    endtask

    task automatic test_back_to_back();
        build(2, 10, 1'b1);
        run_trace("b2b");
    endtask

    task automatic test_nops();
        do_reset();
        foreach (prog[i]) prog[i] = 8'h00;
        build(2, 9, 1'b0);
        run_trace("nops");
    endtask

    task automatic test_jz();
        do_reset();
        foreach (prog[i]) prog[i] = 8'h00;
        prog[2] = 8'hc0; prog[3] = 8'he0;
        build(1, 7, 1'b0);
        run_trace("jz_taken");
        do_reset();
        build(0, 6, 1'b0);
        run_trace("jz_fall");
        checks++;
        if (exp_halted !== 1'b1 || tb_pc !== 3'd3) begin
            failures++; $display("FAIL jz_fall_end pc got=%0d exp=3", tb_pc);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            do_reset();
            foreach (prog[i]) prog[i] = 8'($urandom);
            build(2, 16, 1'b0);
            run_trace($sformatf("rand%0d", t));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        foreach (prog[i]) prog[i] = 8'h00;
        prog[0] = 8'h80;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b1 || pc_clr !== 1'b1) begin
            failures++; $display("FAIL mid_start pc_en/clr got=%b/%b exp=1/1", pc_en, pc_clr);
        end
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_load !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_decode out_load/busy got=%b/%b exp=0/1", out_load, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_load !== 1'b0 || busy !== 1'b0 || pc_en !== 1'b0 || halted !== 1'b0 ||
                ir !== 8'h00) begin
                failures++;
                $display("FAIL mid_after[%0d] out_load=%b busy=%b pc_en=%b halted=%b ir=%h exp 0",
                         i, out_load, busy, pc_en, halted, ir);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef TOYUP_SINGLE_STEP_EN
    task automatic test_step();
        do_reset();
        foreach (prog[i]) prog[i] = 8'h00;
        pause_lo = 6; pause_hi = 6;
        build(2, 3, 1'b0);
        run_trace("step_hold");
        pause_lo = 0; pause_hi = 2;
    endtask
`endif

    initial begin
        foreach (prog[i]) prog[i] = 8'h00;
        test_reset();
        test_program();
        test_back_to_back();
        test_nops();
        test_jz();
        test_reset_mid();
`ifdef TOYUP_SINGLE_STEP_EN
        test_step();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toy_ctrl_seq.md
Name: toy_ctrl_seq

Overview:
- Control sequencer for the toy CPU; sits directly around the 3-bit instruction counter.
- Consumes the counter value (pc) and the program-memory word addressed by it.
- Produces the counter's en/clr controls plus one-cycle datapath strobes.
- Runs a fixed FETCH/DECODE/EXECUTE cycle: 3 clocks per instruction.

Parameters:
- IW, 8, instruction width; opcode = instr[IW-1:IW-3], operand = instr[IW-4:0].
- PCW, 3, pc width; must match the instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin execution from pc 0; honoured only in IDLE or HALT.
- pc  in  PCW  current instruction counter value.
- instr  in  IW  program-memory word at pc (combinational memory).
- acc_zero  in  1  datapath accumulator == 0.
- pc_en  out  1  counter enable.
- pc_clr  out  1  counter clear; meaningful only with pc_en=1.
- ir  out  IW  instruction register.
- imm  out  IW-3  operand field of ir.
- acc_load  out  1  load accumulator from ALU result.
- alu_op  out  2  00 pass imm, 01 add, 10 sub.
- out_load  out  1  load output register from accumulator.
- halted  out  1  high in HALT.
- busy  out  1  high in FETCH, DECODE, EXECUTE.

Behaviour:
- Reset:
  - Synchronous, active-low; one clock cycle with rst=0 forces the reset state at the next edge.
  - State=IDLE; ir=0; all strobes=0; halted=0; busy=0.
  - Reset mid-instruction abandons the instruction; no strobe fires after it.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT.
- IDLE/HALT + start=1:
  - pc_en=1 and pc_clr=1 that cycle; next state FETCH, so FETCH sees pc=0.
  - start=0: hold state.
- FETCH: ir <= instr; next DECODE.
- DECODE:
  - Latch decoded flags from ir: acc_load, alu_op, out_load, jump, cond, hlt.
  - Next state EXECUTE.
- EXECUTE:
  - Latched flags drive outputs for exactly this one cycle.
  - pc_en=1 unless HLT.
  - pc_clr=1 for JMP0, or for JZ0 with acc_zero=1 (sampled this cycle).
  - Next state FETCH, or HALT for HLT.
- Opcodes:
  - 000 NOP.
  - 001 LDA: acc_load, alu_op=00.
  - 010 ADD: acc_load, alu_op=01.
  - 011 SUB: acc_load, alu_op=10.
  - 100 OUT: out_load.
  - 101 JMP0.
  - 110 JZ0.
  - 111 HLT.
- Strobe timing:
  - All strobes are 0 outside EXECUTE.
  - alu_op=00 whenever acc_load=0.
- pc wrap: pc 7 with a non-jump instruction increments to 0; execution continues, no special handling.
- start while busy: ignored.
- HLT: pc is not advanced; in HALT, pc still points at the HLT word.
- imm = ir[IW-4:0] at all times.

Optional Feature:
- Macro: TOYUP_SINGLE_STEP_EN.
- Defined:
  - Extra input port step (1 bit) and extra state PAUSE.
  - Leaving EXECUTE for a non-HLT instruction enters PAUSE instead of FETCH.
  - PAUSE + step=1: next FETCH; step=0: hold.
  - busy=1 in PAUSE.
  - start is ignored in PAUSE.
  - HLT still goes to HALT.
- Undefined: no step port, no PAUSE state; behaviour exactly as above.

Decomposition:
- Shared package toy_cpu_pkg:
  - opcode constants OP_NOP..OP_HLT;
  - ALU_PASS/ALU_ADD/ALU_SUB;
  - state encoding localparams;
  - IW/PCW defaults.
- Natural sub-module toy_decode: combinational ir -> {acc_load, alu_op, out_load, jump, cond, hlt}, instantiated once and registered in DECODE.
- The FSM and registers stay in toy_ctrl_seq.

Test Plan:
- Reset held 2 cycles, then released, start=0 for 5 cycles -> IDLE, all outputs 0, ir=0, pc_en=0.
- start pulse, program {LDA 5, ADD 3, OUT, HLT} with counter model:
  - pc_en=1, pc_clr=1 on the start cycle;
  - acc_load at cycles 3 (alu_op 00, imm 5) and 6 (alu_op 01, imm 3);
  - out_load at 9; halted=1 from 13; pc=3 in HALT.
- Program of 8 NOPs:
  - pc sequence 0..7 then 0, each held 3 cycles;
  - pc_en high only in EXECUTE; pc_clr never asserted.
- JZ0 at pc 2:
  - acc_zero=1 -> pc_clr=1 with pc_en, next FETCH at pc 0;
  - acc_zero=0 -> pc advances to 3.
- rst=0 during DECODE of an OUT instruction -> out_load never asserted; IDLE next cycle; start mid-run is ignored.
- With TOYUP_SINGLE_STEP_EN:
  - NOP program, step held 0 -> parks in PAUSE after first EXECUTE with busy=1;
  - each step pulse advances exactly one instruction.
